// File: rtl/booth_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// booth_operand_sequencer_pkg
// Shared constants and helpers for the Booth multiplier feeder.
// Provides the IDLE/RUN state encoding and the derivation of the Booth
// iteration count (CNT) and operation latency (L). multiplier_booth uses the
// same functions, so both sides always agree on these counts.
// ---------------------------------------------------------------------------
package booth_operand_sequencer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ceiling log2, never less than 1 bit.
  function automatic int clog2_i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Radix-4 Booth: one iteration per pair of multiplier bits.
  function automatic int booth_cnt(input int wa, input int wb);
    return (max_i(wa, wb) + 1) / 2;
  endfunction

  // Done-cycles between an operation completing and its product on OUT.
  function automatic int booth_lat(input int stage);
    return stage + 2;
  endfunction

endpackage

// File: rtl/booth_operand_sequencer_tag.sv
// ---------------------------------------------------------------------------
// booth_tag_pipe
// L-deep valid-tag shift register that follows operations through the Booth
// multiplier. Each shift corresponds to one completed operation.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_shift         advance the chain by one operation
//   i_din           tag entering position 0 on a shift
//   i_clr_top       drop the top tag once its product has been consumed
//   o_top_next      value the top tag takes if a shift happens now
//   o_pend_below    any tag set in positions 0..L-2 (current)
//   o_pend_next     any tag set in positions 0..L-2 after a shift now
//   o_any           any tag set
// ---------------------------------------------------------------------------
module booth_tag_pipe #(
  parameter int L = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_shift,
  input  logic i_din,
  input  logic i_clr_top,
  output logic o_top_next,
  output logic o_pend_below,
  output logic o_pend_next,
  output logic o_any
);

  logic [L-1:0] r_tag;
  logic [L-1:0] w_tag_next;

  assign w_tag_next   = {r_tag[L-2:0], i_din};
  assign o_top_next   = w_tag_next[L-1];
  assign o_pend_below = |r_tag[L-2:0];
  assign o_pend_next  = |w_tag_next[L-2:0];
  assign o_any        = |r_tag;

  // A shift overwrites the top entry, so it takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else if (i_shift) begin
      r_tag <= w_tag_next;
    end else if (i_clr_top) begin
      r_tag[L-1] <= 1'b0;
    end
  end

endmodule

// File: rtl/booth_operand_sequencer.sv
// ---------------------------------------------------------------------------
// booth_operand_sequencer
// Feeds operand pairs to the iterative radix-4 Booth multiplier of a PE,
// holds them for a full operation, tracks which in-flight operations are
// real, and presents each product on a valid/ready result port. Zero-operand
// bubbles are issued automatically to drain the multiplier output pipeline.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    array enable; low freezes everything
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   mul_a/mul_b           held operands to the multiplier
//   mul_pip_en            multiplier pip_en
//   mul_out               multiplier product
//   res_valid/res_ready   result handshake, res_data = mul_out
//   busy                  operation running or real tag in flight
// ---------------------------------------------------------------------------
module booth_operand_sequencer
  import booth_operand_sequencer_pkg::*;
#(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int SIGNED    = 0,
  parameter int STAGE     = 0,
  parameter int WIDTH_MUL = WIDTH_A + WIDTH_B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_b,
  output logic [WIDTH_A-1:0]   mul_a,
  output logic [WIDTH_B-1:0]   mul_b,
  output logic                 mul_pip_en,
  input  logic [WIDTH_MUL-1:0] mul_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH_MUL-1:0] res_data,
  output logic                 busy
);

  localparam int CNT = booth_cnt(WIDTH_A, WIDTH_B);
  localparam int L   = booth_lat(STAGE);
  localparam int CW  = clog2_i(CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT);

  // SIGNED only matters to the multiplier; the sequencer is sign-agnostic.
  if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
    $error("booth_operand_sequencer: SIGNED must be 0 or 1");
  end

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH_A-1:0]   r_mul_a;
  logic [WIDTH_B-1:0]   r_mul_b;
  logic                 r_cur_vld;
  logic                 r_res_valid;

  logic w_done, w_stall, w_pip_en, w_shift, w_slot, w_consume;
  logic w_load, w_bubble, w_pend;
  logic w_top_next, w_pend_below, w_pend_next, w_tag_any;

  assign w_done    = (r_cnt == CNT_LAST);
  // Hold the done cycle while a product is unconsumed so mul_out stays put.
  assign w_stall   = w_done && r_res_valid && !res_ready;
  assign w_pip_en  = en && (r_state == S_RUN) && !w_stall;
  assign w_shift   = w_done && w_pip_en;
  assign w_slot    = (r_state == S_IDLE) || w_shift;
  assign w_consume = en && r_res_valid && res_ready;

  // Drain decision looks at the tag chain as it will be after this edge.
  assign w_pend    = (r_state == S_IDLE) ? w_pend_below : w_pend_next;
  assign w_load    = en && w_slot && in_valid;
  assign w_bubble  = en && w_slot && !in_valid && w_pend;

  booth_tag_pipe #(.L(L)) u_tag_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_shift      (w_shift),
    .i_din        (r_cur_vld),
    .i_clr_top    (w_consume),
    .o_top_next   (w_top_next),
    .o_pend_below (w_pend_below),
    .o_pend_next  (w_pend_next),
    .o_any        (w_tag_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_cur_vld   <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (en) begin
      if (w_pip_en) r_cnt <= w_done ? '0 : r_cnt + 1'b1;

      if (w_shift && w_top_next) r_res_valid <= 1'b1;
      else if (w_consume)        r_res_valid <= 1'b0;

      if (w_load) begin
        r_mul_a   <= in_a;
        r_mul_b   <= in_b;
        r_cur_vld <= 1'b1;
        r_state   <= S_RUN;
      end else if (w_bubble) begin
        r_mul_a   <= '0;
        r_mul_b   <= '0;
        r_cur_vld <= 1'b0;
        r_state   <= S_RUN;
      end else if (w_shift) begin
        r_state   <= S_IDLE;
      end
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held.
  assign in_ready   = rst_n && en && w_slot;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_pip_en = w_pip_en;
  assign res_valid  = r_res_valid;
  assign res_data   = mul_out;
  assign busy       = (r_state != S_IDLE) || w_tag_any;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
`timescale 1ns/1ps
module tb_booth_operand_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance 0: unsigned, STAGE=0 (L=2)
  logic        v0 = 1'b0, rr0 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic        ir0, pe0, rv0, bz0;
  logic [15:0] ma0, mb0;
  logic [31:0] mo0, rd0;

  // Instance 1: signed, STAGE=2 (L=4)
  logic        v1 = 1'b0, rr1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        ir1, pe1, rv1, bz1;
  logic [15:0] ma1, mb1;
  logic [31:0] mo1, rd1;

  booth_operand_sequencer #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(0), .STAGE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v0), .in_ready(ir0),
    .in_a(a0), .in_b(b0), .mul_a(ma0), .mul_b(mb0), .mul_pip_en(pe0),
    .mul_out(mo0), .res_valid(rv0), .res_ready(rr0), .res_data(rd0), .busy(bz0));

  booth_operand_sequencer #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1), .STAGE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .mul_a(ma1), .mul_b(mb1), .mul_pip_en(pe1),
    .mul_out(mo1), .res_valid(rv1), .res_ready(rr1), .res_data(rd1), .busy(bz1));

  // Stand-in multipliers: 9 enabled cycles per op (CNT=8); OUT shows the
  // product of the op completed L-1 done-cycles earlier.
  logic [3:0]  mc0, mc1;
  logic [31:0] mp0 [0:1];
  logic [31:0] mp1 [0:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc0 <= '0; mp0[0] <= '0; mp0[1] <= '0;
    end else if (pe0) begin
      if (mc0 == 4'd8) begin
        mc0 <= '0;
        mp0[0] <= {16'd0, ma0} * {16'd0, mb0};
        mp0[1] <= mp0[0];
      end else mc0 <= mc0 + 4'd1;
    end
  end
  assign mo0 = mp0[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc1 <= '0; mp1[0] <= '0; mp1[1] <= '0; mp1[2] <= '0; mp1[3] <= '0;
    end else if (pe1) begin
      if (mc1 == 4'd8) begin
        mc1 <= '0;
        mp1[0] <= $signed({{16{ma1[15]}}, ma1}) * $signed({{16{mb1[15]}}, mb1});
        mp1[1] <= mp1[0];
        mp1[2] <= mp1[1];
        mp1[3] <= mp1[2];
      end else mc1 <= mc1 + 4'd1;
    end
  end
  assign mo1 = mp1[3];

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready0: got %b want 0", ir0); end
    n_chk++; if (ma0 !== 16'd0 || mb0 !== 16'd0) begin n_fail++; $display("FAIL reset_mul_ab0: got %h/%h want 0/0", ma0, mb0); end
    n_chk++; if (pe0 !== 1'b0) begin n_fail++; $display("FAIL reset_pip_en0: got %b want 0", pe0); end
    n_chk++; if (rv0 !== 1'b0 || bz0 !== 1'b0) begin n_fail++; $display("FAIL reset_rv_busy0: got %b/%b want 0/0", rv0, bz0); end
    n_chk++; if (ir1 !== 1'b0 || pe1 !== 1'b0 || rv1 !== 1'b0 || bz1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut1: ir/pe/rv/busy %b%b%b%b want 0000", ir1, pe1, rv1, bz1); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++; if (ir0 !== 1'b1 || pe0 !== 1'b0) begin n_fail++; $display("FAIL release_idle0: ir/pe %b%b want 10", ir0, pe0); end
  endtask

  task automatic test_single_op();
    int first_rv;
    first_rv = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      v0 = (cyc == 0); a0 = (cyc == 0) ? 16'd3 : 16'd0; b0 = (cyc == 0) ? 16'd5 : 16'd0;
      rr0 = (first_rv >= 0);
      #1;
      if (cyc == 0) begin
        n_chk++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", ir0); end
      end
      if (cyc == 5) begin
        n_chk++; if (ma0 !== 16'd3 || mb0 !== 16'd5 || pe0 !== 1'b1) begin
          n_fail++; $display("FAIL single_held: a=%0d b=%0d pe=%b want 3 5 1", ma0, mb0, pe0); end
      end
      if (cyc == 10) begin
        n_chk++; if (ma0 !== 16'd0 || mb0 !== 16'd0 || pe0 !== 1'b1) begin
          n_fail++; $display("FAIL single_bubble: a=%0d b=%0d pe=%b want 0 0 1", ma0, mb0, pe0); end
      end
      if (rv0 === 1'b1 && first_rv < 0) begin
        first_rv = cyc;
        n_chk++; if (rd0 !== 32'd15 || bz0 !== 1'b1) begin n_fail++; $display("FAIL single_result: data=%0d busy=%b want 15 1", rd0, bz0); end
      end
      if (first_rv >= 0 && cyc == first_rv + 2) begin
        n_chk++; if (rv0 !== 1'b0 || bz0 !== 1'b0) begin n_fail++; $display("FAIL single_consumed: rv=%b busy=%b want 0 0", rv0, bz0); end
      end
    end
    n_chk++; if (first_rv != 19) begin n_fail++; $display("FAIL single_latency: got %0d want 19", first_rv); end
    rr0 = 1'b0;
  endtask

  task automatic test_signed();
    logic [15:0] va [0:1];
    logic [15:0] vb [0:1];
    logic [31:0] ex [0:1];
    int first_rv;
    va[0] = 16'hFFFD; vb[0] = 16'd7;    ex[0] = 32'hFFFFFFEB;
    va[1] = 16'h8000; vb[1] = 16'h8000; ex[1] = 32'h40000000;
    for (int t = 0; t < 2; t++) begin
      first_rv = -1;
      rr1 = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
        @(negedge clk);
        v1 = (cyc == 0); a1 = (cyc == 0) ? va[t] : 16'd0; b1 = (cyc == 0) ? vb[t] : 16'd0;
        #1;
        if (rv1 === 1'b1 && first_rv < 0) begin
          first_rv = cyc;
          n_chk++; if (rd1 !== ex[t]) begin n_fail++; $display("FAIL signed_result%0d: got %h want %h", t, rd1, ex[t]); end
        end
      end
      n_chk++; if (first_rv != 37) begin n_fail++; $display("FAIL signed_latency%0d: got %0d want 37", t, first_rv); end
      n_chk++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL signed_idle%0d: busy=%b want 0", t, bz1); end
    end
    rr1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] res[$];
    int idx, zc;
    idx = 0; zc = 0;
    rr1 = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      @(negedge clk);
      v1 = (idx < 4);
      a1 = (idx < 4) ? 16'(idx + 1) : 16'd0;
      b1 = a1;
      #1;
      if (rv1 && rr1) res.push_back(rd1);
      if (pe1 && ma1 == 16'd0 && mb1 == 16'd0) zc++;
      if (ir1 && v1) begin acc.push_back(cyc); idx++; end
    end
    n_chk++; if (acc.size() != 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_chk++; if (acc[i] - acc[i-1] != 9) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 9", i, acc[i] - acc[i-1]); end
    end
    n_chk++; if (res.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", res.size()); end
    for (int i = 0; i < res.size() && i < 4; i++) begin
      n_chk++; if (res[i] !== 32'((i + 1) * (i + 1))) begin n_fail++; $display("FAIL b2b_result%0d: got %0d want %0d", i, res[i], (i + 1) * (i + 1)); end
    end
    n_chk++; if (zc != 27) begin n_fail++; $display("FAIL b2b_bubbles: zero-operand cycles %0d want 27", zc); end
    n_chk++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", bz1); end
    rr1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [0:1];
    logic [15:0] ob [0:1];
    logic [31:0] res[$];
    int idx, pc;
    oa[0] = 16'd2; ob[0] = 16'd3; oa[1] = 16'd4; ob[1] = 16'd5;
    idx = 0; pc = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      v0 = (idx < 2);
      a0 = (idx < 2) ? oa[idx] : 16'd0;
      b0 = (idx < 2) ? ob[idx] : 16'd0;
      rr0 = (cyc >= 33);
      #1;
      if (pe0) pc++;
      if (rv0 && rr0) res.push_back(rd0);
      if (cyc >= 27 && cyc <= 32) begin
        n_chk++; if (pe0 !== 1'b0 || rv0 !== 1'b1 || rd0 !== 32'd6) begin
          n_fail++; $display("FAIL bp_stall_c%0d: pe=%b rv=%b data=%0d want 0 1 6", cyc, pe0, rv0, rd0); end
      end
      if (ir0 && v0) idx++;
    end
    n_chk++; if (res.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", res.size()); end
    else begin
      n_chk++; if (res[0] !== 32'd6 || res[1] !== 32'd20) begin n_fail++; $display("FAIL bp_order: got %0d,%0d want 6,20", res[0], res[1]); end
    end
    n_chk++; if (pc != 27) begin n_fail++; $display("FAIL bp_pip_cycles: got %0d want 27", pc); end
    n_chk++; if (bz0 !== 1'b0) begin n_fail++; $display("FAIL bp_idle: busy=%b want 0", bz0); end
    rr0 = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic [31:0] res[$];
    int first_rv, pc;
    first_rv = -1; pc = 0;
    rr1 = 1'b1;
    for (int cyc = 0; cyc < 55; cyc++) begin
      @(negedge clk);
      v1 = (cyc == 0); a1 = (cyc == 0) ? 16'd9 : 16'd0; b1 = (cyc == 0) ? 16'd11 : 16'd0;
      en = !(cyc >= 5 && cyc <= 9);
      #1;
      if (pe1) pc++;
      if (cyc >= 5 && cyc <= 9) begin
        n_chk++; if (pe1 !== 1'b0 || ma1 !== 16'd9 || mb1 !== 16'd11 || ir1 !== 1'b0 || bz1 !== 1'b1) begin
          n_fail++; $display("FAIL en_frozen_c%0d: pe=%b a=%0d b=%0d ir=%b busy=%b want 0 9 11 0 1", cyc, pe1, ma1, mb1, ir1, bz1); end
      end
      if (rv1 && first_rv < 0) first_rv = cyc;
      if (rv1 && rr1 && en) res.push_back(rd1);
    end
    en = 1'b1;
    n_chk++; if (first_rv != 42) begin n_fail++; $display("FAIL en_latency: got %0d want 42", first_rv); end
    n_chk++; if (res.size() != 1 || res[0] !== 32'd99) begin
      n_fail++; $display("FAIL en_result: count %0d first %0d want 1 99", res.size(), (res.size() > 0) ? res[0] : 32'd0); end
    n_chk++; if (pc != 36) begin n_fail++; $display("FAIL en_pip_cycles: got %0d want 36", pc); end
    rr1 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res[$];
    int first_rv;
    first_rv = -1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      v0 = (cyc == 0); a0 = (cyc == 0) ? 16'd5 : 16'd0; b0 = (cyc == 0) ? 16'd9 : 16'd0;
      if (cyc == 5) rst_n = 1'b0;
      #1;
    end
    n_chk++; if (ir0 !== 1'b0 || pe0 !== 1'b0 || rv0 !== 1'b0 || bz0 !== 1'b0 || ma0 !== 16'd0 || mb0 !== 16'd0) begin
      n_fail++; $display("FAIL midreset_outputs: ir=%b pe=%b rv=%b busy=%b a=%0d b=%0d want all 0", ir0, pe0, rv0, bz0, ma0, mb0); end
    @(negedge clk); rst_n = 1'b1;
    rr0 = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      v0 = (cyc == 0); a0 = (cyc == 0) ? 16'd6 : 16'd0; b0 = (cyc == 0) ? 16'd7 : 16'd0;
      #1;
      if (rv0 && first_rv < 0) first_rv = cyc;
      if (rv0 && rr0) res.push_back(rd0);
    end
    n_chk++; if (first_rv != 19) begin n_fail++; $display("FAIL midreset_latency: got %0d want 19", first_rv); end
    n_chk++; if (res.size() != 1 || res[0] !== 32'd42) begin
      n_fail++; $display("FAIL midreset_result: count %0d first %0d want 1 42", res.size(), (res.size() > 0) ? res[0] : 32'd0); end
    rr0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_en_toggle();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_chk, n_fail);
    $fatal(1, "time limit");
  end

endmodule
